// File: rtl/cache_base_ctrl_pkg.sv
// rtl/cache_base_ctrl_pkg.sv - shared geometry, state encoding and request-type constants for the baseline cache
package cache_base_ctrl_pkg;

    localparam int CACHE_TAG_W          = 21;
    localparam int CACHE_INDEX_W        = 5;
    localparam int CACHE_WORD_OFF_W     = 4;
    localparam int CACHE_BYTE_OFF_W     = 2;
    localparam int CACHE_WORDS_PER_LINE = 16;
    localparam int CACHE_NUM_LINES      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG_CHECK,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_REFILL_REQ,
        ST_REFILL_WAIT,
        ST_RESP
    } state_e;

    localparam logic CREQ_TYPE_REFILL = 1'b0;
    localparam logic CREQ_TYPE_WRITE  = 1'b1;

    localparam logic WMUX_SEL_PROC = 1'b0;
    localparam logic WMUX_SEL_MEM  = 1'b1;

endpackage

// File: rtl/cache_valid_array.sv
// rtl/cache_valid_array.sv - per-line valid bits: reset clear, single set port, combinational read
module cache_valid_array #(
    parameter int  NUM_LINES = 32,
    localparam int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;

    always_comb begin
        valid_d = valid_q;
        if (set_en) begin
            valid_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/cache_base_ctrl.sv
// rtl/cache_base_ctrl.sv - control FSM for the direct-mapped write-through no-write-allocate cache
module cache_base_ctrl
    import cache_base_ctrl_pkg::*;
#(
    parameter int  NUM_LINES      = CACHE_NUM_LINES,
    parameter int  WORDS_PER_LINE = CACHE_WORDS_PER_LINE,
    localparam int IDX_W          = $clog2(NUM_LINES),
    localparam int CNT_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memreq_val,
    output logic             memreq_rdy,
    output logic             memresp_val,
    input  logic             memresp_rdy,
    output logic             cachereq_val,
    input  logic             cachereq_rdy,
    output logic             cachereq_type,
    input  logic             cacheresp_val,
    output logic             cacheresp_rdy,
    output logic             data_array_r_en,
    output logic             data_array_w_en,
    output logic             data_array_write_mux_sel,
    output logic             tag_array_w_en,
    output logic [CNT_W-1:0] refill_cnt,
    input  logic             tag_array_match,
    input  logic [IDX_W-1:0] index,
    input  logic             read
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] refill_cnt_q, refill_cnt_d;
    logic             line_valid;
    logic             hit;
    logic             last_beat;
    logic             valid_set;

    cache_valid_array #(
        .NUM_LINES (NUM_LINES)
    ) u_valid (
        .clk      (clk),
        .reset    (reset),
        .set_en   (valid_set),
        .set_idx  (index),
        .rd_idx   (index),
        .rd_valid (line_valid)
    );

    assign hit       = line_valid & tag_array_match;
    assign last_beat = (refill_cnt_q == CNT_W'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            refill_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            refill_cnt_q <= refill_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        refill_cnt_d = refill_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (memreq_val) state_d = ST_TAG_CHECK;
            end
            ST_TAG_CHECK: begin
                if (!read) begin
                    state_d = ST_WR_REQ;
                end else if (hit) begin
                    state_d = ST_RESP;
                end else begin
                    state_d      = ST_REFILL_REQ;
                    refill_cnt_d = '0;
                end
            end
            ST_WR_REQ: begin
                if (cachereq_rdy) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (cacheresp_val) state_d = ST_RESP;
            end
            ST_REFILL_REQ: begin
                if (cachereq_rdy) state_d = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                if (cacheresp_val) begin
                    // Last beat returns to TAG_CHECK so the now-valid line is re-read and hits.
                    if (last_beat) begin
                        refill_cnt_d = '0;
                        state_d      = ST_TAG_CHECK;
                    end else begin
                        refill_cnt_d = refill_cnt_q + 1'b1;
                        state_d      = ST_REFILL_REQ;
                    end
                end
            end
            ST_RESP: begin
                if (memresp_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        memreq_rdy               = 1'b0;
        memresp_val              = 1'b0;
        cachereq_val             = 1'b0;
        cachereq_type            = CREQ_TYPE_REFILL;
        cacheresp_rdy            = 1'b0;
        data_array_r_en          = 1'b0;
        data_array_w_en          = 1'b0;
        data_array_write_mux_sel = WMUX_SEL_PROC;
        tag_array_w_en           = 1'b0;
        valid_set                = 1'b0;
        case (state_q)
            ST_IDLE: memreq_rdy = 1'b1;
            ST_TAG_CHECK: begin
                data_array_r_en = 1'b1;
                // Write hit updates the cached word; a write miss leaves the array alone.
                if (!read && hit) data_array_w_en = 1'b1;
            end
            ST_WR_REQ: begin
                cachereq_val  = 1'b1;
                cachereq_type = CREQ_TYPE_WRITE;
            end
            ST_WR_WAIT: cacheresp_rdy = 1'b1;
            ST_REFILL_REQ: begin
                cachereq_val  = 1'b1;
                cachereq_type = CREQ_TYPE_REFILL;
            end
            ST_REFILL_WAIT: begin
                cacheresp_rdy = 1'b1;
                if (cacheresp_val) begin
                    data_array_w_en          = 1'b1;
                    data_array_write_mux_sel = WMUX_SEL_MEM;
                    tag_array_w_en           = last_beat;
                    valid_set                = last_beat;
                end
            end
            ST_RESP: begin
                memresp_val     = 1'b1;
                data_array_r_en = read;
            end
            default: ;
        endcase
    end

    assign refill_cnt = refill_cnt_q;

endmodule

// File: tb/tb_cache_base_ctrl.sv
// tb/tb_cache_base_ctrl.sv - directed table-driven bench with datapath and memory models
module tb_cache_base_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       memreq_val;
    logic       memreq_rdy;
    logic       memresp_val;
    logic       memresp_rdy;
    logic       cachereq_val;
    logic       cachereq_rdy;
    logic       cachereq_type;
    logic       cacheresp_val;
    logic       cacheresp_rdy;
    logic       data_array_r_en;
    logic       data_array_w_en;
    logic       data_array_write_mux_sel;
    logic       tag_array_w_en;
    logic [3:0] refill_cnt;
    logic       tag_array_match;
    logic [4:0] index;
    logic       read;

    logic [31:0] req_addr;
    logic        req_read;
    logic [31:0] req_wdata;
    logic [20:0] tag_arr [32];
    logic [31:0] data_arr [32][16];
    logic [31:0] mem [logic [31:0]];

    int nchk = 0;
    int nerr = 0;

    assign index           = req_addr[10:6];
    assign read            = req_read;
    assign tag_array_match = (tag_arr[req_addr[10:6]] == req_addr[31:11]);

    always #5 clk = ~clk;

    cache_base_ctrl dut (
        .clk                      (clk),
        .reset                    (reset),
        .memreq_val               (memreq_val),
        .memreq_rdy               (memreq_rdy),
        .memresp_val              (memresp_val),
        .memresp_rdy              (memresp_rdy),
        .cachereq_val             (cachereq_val),
        .cachereq_rdy             (cachereq_rdy),
        .cachereq_type            (cachereq_type),
        .cacheresp_val            (cacheresp_val),
        .cacheresp_rdy            (cacheresp_rdy),
        .data_array_r_en          (data_array_r_en),
        .data_array_w_en          (data_array_w_en),
        .data_array_write_mux_sel (data_array_write_mux_sel),
        .tag_array_w_en           (tag_array_w_en),
        .refill_cnt               (refill_cnt),
        .tag_array_match          (tag_array_match),
        .index                    (index),
        .read                     (read)
    );

    typedef struct {
        logic [31:0] addr;
        bit          rd;
        logic [31:0] wdata;
        bit          stall;
        int          abort_beat;
        int          exp_ref;
        int          exp_wt;
        int          exp_lat;
        bit          exp_resp;
        bit          chk_data;
        logic [31:0] exp_data;
        bit          exp_tcw;
        bit          exp_valid;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input bit rd, input logic [31:0] wdata,
                                input bit stall, input int abort_beat, input int exp_ref,
                                input int exp_wt, input int exp_lat, input bit exp_resp,
                                input bit chk_data, input logic [31:0] exp_data,
                                input bit exp_tcw, input bit exp_valid);
        vec_t v;
        v.addr = addr; v.rd = rd; v.wdata = wdata; v.stall = stall; v.abort_beat = abort_beat;
        v.exp_ref = exp_ref; v.exp_wt = exp_wt; v.exp_lat = exp_lat; v.exp_resp = exp_resp;
        v.chk_data = chk_data; v.exp_data = exp_data; v.exp_tcw = exp_tcw; v.exp_valid = exp_valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_memreq_rdy"}, 32'(memreq_rdy), 32'd1);
        chk({name, "_outs"}, 32'({memresp_val, cachereq_val, cachereq_type, cacheresp_rdy,
                                  data_array_r_en, data_array_w_en, data_array_write_mux_sel,
                                  tag_array_w_en}), 32'd0);
        chk({name, "_refill_cnt"}, 32'(refill_cnt), 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input int n);
        int          cyc = 0;
        int          lat = -1;
        int          nref = 0;
        int          nwt = 0;
        int          hold = 0;
        bit          tcw = 0;
        bit          done = 0;
        bit          got_resp = 0;
        bit          pend = 0;
        logic [31:0] pend_addr = '0;
        logic [31:0] rdata = '0;
        bit          p_req = 0, p_wait = 0, p_resp = 0;
        logic [5:0]  p_req_vec = '0;
        logic [1:0]  p_resp_vec = '0;
        string       tn;
        tn = $sformatf("v%0d", n);

        @(negedge clk);
        memreq_val = 1'b1;
        req_addr   = v.addr;
        req_read   = v.rd;
        req_wdata  = v.wdata;
        #1;
        chk({tn, "_accept"}, 32'(memreq_rdy), 32'd1);
        @(negedge clk);
        memreq_val = 1'b0;
        cyc = 1;
        while (!done && cyc < 2000) begin
            cachereq_rdy  = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            cacheresp_val = pend && (v.stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            memresp_rdy   = !v.stall || (hold >= 5);
            #1;
            if (p_req)  chk({tn, "_req_hold"}, 32'({cachereq_val, cachereq_type, refill_cnt}), 32'(p_req_vec));
            if (p_wait) chk({tn, "_wait_hold"}, 32'(cacheresp_rdy), 32'd1);
            if (p_resp) chk({tn, "_resp_hold"}, 32'({memresp_val, data_array_r_en}), 32'(p_resp_vec));
            if (data_array_w_en) begin
                if (data_array_write_mux_sel) data_arr[index][refill_cnt] = memword(pend_addr);
                else begin
                    data_arr[index][req_addr[5:2]] = req_wdata;
                    tcw = 1;
                end
            end
            if (tag_array_w_en) tag_arr[index] = req_addr[31:11];
            if (cacheresp_val && cacheresp_rdy) pend = 0;
            if (cachereq_val && cachereq_rdy) begin
                if (cachereq_type == 1'b0) begin
                    chk({tn, "_beat_cnt"}, 32'(refill_cnt), 32'(nref));
                    pend_addr = {req_addr[31:11], index, refill_cnt, 2'b00};
                    nref++;
                end else begin
                    pend_addr = req_addr;
                    mem[req_addr] = req_wdata;
                    nwt++;
                end
                pend = 1;
            end
            if (memresp_val) begin
                if (lat < 0) lat = cyc;
                got_resp = 1;
                if (memresp_rdy) begin
                    rdata = data_arr[index][req_addr[5:2]];
                    done = 1;
                end else hold++;
            end
            p_req      = cachereq_val && !cachereq_rdy;
            p_req_vec  = {cachereq_val, cachereq_type, refill_cnt};
            p_wait     = cacheresp_rdy && !cacheresp_val;
            p_resp     = memresp_val && !memresp_rdy;
            p_resp_vec = {memresp_val, data_array_r_en};
            if (v.abort_beat > 0 && nref == v.abort_beat) begin
                reset = 1'b1;
                pend  = 0;
                @(negedge clk);
                reset = 1'b0;
                #1;
                chk_idle({tn, "_abort"});
                chk({tn, "_abort_valid"}, 32'(dut.u_valid.valid_q[v.addr[10:6]]), 32'd0);
                done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        cachereq_rdy  = 1'b1;
        cacheresp_val = 1'b0;
        memresp_rdy   = 1'b1;
        #1;
        chk({tn, "_timeout"}, 32'(done), 32'd1);
        chk({tn, "_back_idle"}, 32'(memreq_rdy), 32'd1);
        chk({tn, "_resp_seen"}, 32'(got_resp), 32'(v.exp_resp));
        chk({tn, "_refill_reqs"}, 32'(nref), 32'(v.exp_ref));
        chk({tn, "_wt_reqs"}, 32'(nwt), 32'(v.exp_wt));
        chk({tn, "_tc_wen"}, 32'(tcw), 32'(v.exp_tcw));
        if (v.exp_lat >= 0) chk({tn, "_latency"}, 32'(lat), 32'(v.exp_lat));
        if (v.chk_data) chk({tn, "_rdata"}, rdata, v.exp_data);
        chk({tn, "_valid"}, 32'(dut.u_valid.valid_q[v.addr[10:6]]), 32'(v.exp_valid));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tag_arr[i] = '0;
            for (int j = 0; j < 16; j++) data_arr[i][j] = '0;
        end
        reset = 1'b1; memreq_val = 1'b0; memresp_rdy = 1'b1;
        cachereq_rdy = 1'b1; cacheresp_val = 1'b0;
        req_addr = '0; req_read = 1'b1; req_wdata = '0;

        //              addr          rd wdata          st ab  ref wt lat resp chk data              tcw vld
        vecs[0] = mk(32'h0000_1040, 1, 32'h0,          0, 0, 16, 0, 35, 1, 1, pat(32'h1040),     0, 1);
        vecs[1] = mk(32'h0000_1044, 1, 32'h0,          0, 0,  0, 0,  2, 1, 1, pat(32'h1044),     0, 1);
        vecs[2] = mk(32'h0000_1048, 0, 32'hDEAD_BEEF,  0, 0,  0, 1,  4, 1, 0, 32'h0,             1, 1);
        vecs[3] = mk(32'h0000_1048, 1, 32'h0,          0, 0,  0, 0,  2, 1, 1, 32'hDEAD_BEEF,     0, 1);
        vecs[4] = mk(32'h0000_2000, 0, 32'h1234_5678,  0, 0,  0, 1,  4, 1, 0, 32'h0,             0, 0);
        vecs[5] = mk(32'h0000_3080, 1, 32'h0,          1, 0, 16, 0, -1, 1, 1, pat(32'h3080),     0, 1);
        vecs[6] = mk(32'h0000_1840, 1, 32'h0,          0, 0, 16, 0, 35, 1, 1, pat(32'h1840),     0, 1);
        vecs[7] = mk(32'h0000_1048, 1, 32'h0,          0, 0, 16, 0, 35, 1, 1, 32'hDEAD_BEEF,     0, 1);
        vecs[8] = mk(32'h0000_50C0, 1, 32'h0,          0, 7,  7, 0, -1, 0, 0, 32'h0,             0, 0);
        vecs[9] = mk(32'h0000_50C0, 1, 32'h0,          0, 0, 16, 0, 35, 1, 1, pat(32'h50C0),     0, 1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk_idle("reset");
        chk("reset_valid", dut.u_valid.valid_q, 32'd0);

        for (int k = 0; k < 10; k++) run_txn(vecs[k], k);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/cache_base_ctrl.md
# cache_base_ctrl

Control unit for the baseline direct-mapped, write-through, no-write-allocate cache. It sequences the cache datapath: tag check, 16-word line refill on a read miss, word write-through on every store, and the response to the processor. It sits between the processor-side and memory-side val/rdy handshakes and drives the datapath's SRAM enables, the write-mux select and the refill word counter. It holds the per-line valid bits.

## Interface
Parameters:
- NUM_LINES, 32, number of cache lines; also the width of the valid-bit vector.
- WORDS_PER_LINE, 16, number of words per line; also the refill beat count.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- memreq_val, in, 1, processor request valid.
- memreq_rdy, out, 1, controller can accept a request; also the enable for the datapath request register.
- memresp_val, out, 1, response to processor valid.
- memresp_rdy, in, 1, processor accepts the response.
- cachereq_val, out, 1, memory request valid.
- cachereq_rdy, in, 1, memory accepts the request.
- cachereq_type, out, 1, 0 = refill read of word refill_cnt of the line; 1 = write-through of the processor word.
- cacheresp_val, in, 1, memory response valid.
- cacheresp_rdy, out, 1, controller accepts the memory response.
- data_array_r_en, out, 1, data SRAM read enable.
- data_array_w_en, out, 1, data SRAM write enable.
- data_array_write_mux_sel, out, 1, 0 = processor data; 1 = memory response data.
- tag_array_w_en, out, 1, write the request tag at index.
- refill_cnt, out, 4, refill word number; selects the write word during refill.
- tag_array_match, in, 1, stored tag equals the request tag.
- index, in, 5, line index of the registered request.
- read, in, 1, 1 = registered request is a read.

## Operation
States: IDLE, TAG_CHECK, WR_REQ, WR_WAIT, REFILL_REQ, REFILL_WAIT, RESP. Outputs not listed for a state are 0. hit = valid[index] & tag_array_match.

- IDLE:
  - memreq_rdy=1.
  - memreq_val → TAG_CHECK.
- TAG_CHECK:
  - data_array_r_en=1.
  - read & hit → RESP.
  - read & !hit → REFILL_REQ, refill_cnt=0.
  - !read → WR_REQ. On a write hit, also assert data_array_w_en=1 with mux_sel=0 in this cycle. A write miss does not allocate.
- WR_REQ:
  - cachereq_val=1, cachereq_type=1.
  - cachereq_rdy → WR_WAIT.
- WR_WAIT:
  - cacheresp_rdy=1.
  - cacheresp_val → RESP.
- REFILL_REQ:
  - cachereq_val=1, cachereq_type=0.
  - The datapath forms the address {tag, index, refill_cnt, 2'b00}.
  - cachereq_rdy → REFILL_WAIT.
- REFILL_WAIT:
  - cacheresp_rdy=1.
  - On cacheresp_val: data_array_w_en=1, mux_sel=1.
  - If refill_cnt != 15: refill_cnt+1 → REFILL_REQ.
  - If refill_cnt == 15: tag_array_w_en=1, set valid[index], refill_cnt←0 → TAG_CHECK. The re-check then hits.
- RESP:
  - memresp_val=1, data_array_r_en=read.
  - memresp_rdy → IDLE.
  - Write response data is don't-care.
- The refill counter is a 4-bit register. It wraps 15→0 only on the last beat and is never incremented outside REFILL_WAIT.
- Valid bits:
  - Cleared only by reset.
  - Set only on the last refill beat.
  - A write miss leaves valid unchanged.

## Timing
- Reset: state=IDLE, valid=0, refill_cnt=0. In IDLE, memreq_rdy=1 and every other output is 0.
- Reset asserted in any state:
  - Next cycle is IDLE.
  - Any partial refill is abandoned and the line stays invalid.
  - No response is issued.
- One request is in flight at a time. memreq_rdy=0 outside IDLE, so the request register holds.
- Read hit: request accepted at cycle 0, TAG_CHECK at 1, memresp_val at 2.
- Write, with memory accepting at once and responding one cycle later: memresp_val at cycle 4.
- Read miss, with memory accepting at once and responding one cycle later: 32 refill cycles (2..33), re-check at 34, memresp_val at 35.
- Stalls:
  - cachereq_rdy=0 holds REQ states with outputs stable.
  - cacheresp_val=0 holds WAIT states.
  - memresp_rdy=0 holds RESP with data stable.
- Memory responses are assumed in order, one per request.
- A response arriving in any state other than a WAIT state is not accepted (cacheresp_rdy=0).

## Structure
- Shared cache package holds:
  - The state enum.
  - Geometry constants: tag 21, index 5, word offset 4, byte offset 2, words per line 16, lines 32.
  - The cachereq_type encodings.
- One sub-module, cache_valid_array: NUM_LINES×1 flops, synchronous reset clear, one set port, one combinational read port.
- FSM and refill counter live in cache_base_ctrl.

## Test plan
- Reset, then read 0x0000_1040 → refill of 16 beats to addresses 0x1040..0x107C with refill_cnt 0..15; response returns the memory word for 0x1040; valid[1]=1.
- Read 0x0000_1044 after the previous test → memresp_val two cycles after acceptance, no cachereq_val.
- Write 0xDEADBEEF to 0x1048 (hit) → data_array_w_en in TAG_CHECK, one write-through request; a later read of 0x1048 returns 0xDEADBEEF.
- Write to 0x2000 (miss) → one write-through request, no refill; valid[0] stays 0.
- Read 0x3080 with cachereq_rdy and cacheresp_val randomly deasserted and memresp_rdy=0 for 5 cycles → exactly 16 refill requests, outputs stable during stalls, one correct response.
- Reset asserted mid-refill at beat 7 → IDLE next cycle, valid[index]=0, refill_cnt=0; a repeated read performs a full 16-beat refill.
